// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   XLEN          : operand/result width
//   MD_*          : funct3 encodings of the M-extension operations
//   md_state_e    : FSM state encoding of muldiv_unit
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned multiply/divide datapath (combinational).
//   is_div  : 1 = restoring shift-compare-subtract, 0 = radix-2 shift-add
//   acc_in  : {high half, low half} working register
//   opnd    : multiplicand (mul) or divisor (div) magnitude
//   acc_out : working register after this iteration
// Multiply: high half accumulates, low half holds the multiplier and shifts
// right, so after W steps acc holds the 2W-bit product.
// Divide: high half is the partial remainder, low half starts as the dividend
// and shifts left while quotient bits enter at bit 0.
module muldiv_step
  import riscv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             is_div,
  input  logic [2*W-1:0]   acc_in,
  input  logic [W-1:0]     opnd,
  output logic [2*W-1:0]   acc_out
);

  logic [W:0]   sum;
  logic [W:0]   rem_sh;
  logic [W-1:0] diff;

  always_comb begin
    sum     = '0;
    rem_sh  = '0;
    diff    = '0;
    acc_out = acc_in;
    if (is_div) begin
      // Shifted remainder can need W+1 bits before the compare.
      rem_sh = {acc_in[2*W-1:W], acc_in[W-1]};
      // When the subtract is taken the difference is below the divisor, so
      // the low W bits are exact.
      diff   = rem_sh[W-1:0] - opnd;
      if (rem_sh >= {1'b0, opnd}) begin
        acc_out = {diff, acc_in[W-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh[W-1:0], acc_in[W-2:0], 1'b0};
      end
    end else begin
      sum     = {1'b0, acc_in[2*W-1:W]} + (acc_in[0] ? {1'b0, opnd} : {(W+1){1'b0}});
      acc_out = {sum, acc_in[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
//   clk, rst          : clock, synchronous active-high reset
//   start, op         : request and funct3 of the M-extension operation
//   rs1_data/rs2_data : forwarded operands, latched when the op is accepted
//   flush             : abort current operation / ignore start
//   stall_req         : combinational stall request to the hazard unit
//   busy              : registered, high while iterating
//   done              : registered one-cycle result-valid pulse
//   result            : registered result, held until the next done
// Operands are reduced to magnitudes on entry; the unsigned core runs 32
// iterations and the sign is restored on the final edge.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       opnd_q, opnd_d;
  logic                  neg_q, neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [XLEN-1:0]       result_q, result_d;

  logic                  signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0]       a_mag, b_mag;
  logic                  div_by_zero, sgn_ovf;
  logic [2*XLEN-1:0]     step_acc, prod_fix;
  logic [XLEN-1:0]       quo_fix, rem_fix, final_res;

  // MUL is treated as signed x signed; the low half is identical either way.
  always_comb begin
    signed_a    = (op != MD_MULHU) && (op != MD_DIVU) && (op != MD_REMU);
    signed_b    = signed_a && (op != MD_MULHSU);
    a_neg       = signed_a & rs1_data[XLEN-1];
    b_neg       = signed_b & rs2_data[XLEN-1];
    a_mag       = a_neg ? -rs1_data : rs1_data;
    b_mag       = b_neg ? -rs2_data : rs2_data;
    div_by_zero = op[2] & (rs2_data == '0);
    sgn_ovf     = op[2] & ~op[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                  & (rs2_data == '1);
  end

  muldiv_step #(.W(XLEN)) u_step (
    .is_div  (op_q[2]),
    .acc_in  (acc_q),
    .opnd    (opnd_q),
    .acc_out (step_acc)
  );

  // Sign correction applied to the output of the last iteration.
  always_comb begin
    prod_fix  = neg_q ? -step_acc : step_acc;
    quo_fix   = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    rem_fix   = rem_neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
    final_res = prod_fix[XLEN-1:0];
    case (op_q)
      MD_MUL:                       final_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              final_res = quo_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          op_d      = op;
          acc_d     = {{XLEN{1'b0}}, a_mag};
          opnd_d    = b_mag;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          cnt_d     = '0;
          if (div_by_zero) begin
            // op[1] separates REM* from DIV*.
            result_d = op[1] ? rs1_data : '1;
            state_d  = ST_DONE;
            done_d   = 1'b1;
          end else if (sgn_ovf) begin
            result_d = op[1] ? '0 : rs1_data;
            state_d  = ST_DONE;
            done_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
            busy_d  = 1'b1;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {CNT_W{1'b1}}) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = final_res;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  // Combinational so the pipeline freezes in the very cycle start is seen.
  assign stall_req = ((state_q == ST_IDLE) & start & ~flush) | (state_q == ST_CALC);
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] rs1_i = 32'd0;
  logic [31:0] rs2_i = 32'd0;
  logic        flush = 1'b0;
  logic        stall_req, busy, done;
  logic [31:0] result;

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op_i),
    .rs1_data  (rs1_i),
    .rs2_data  (rs2_i),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rst_edge = 1'b0;
  logic chk_en = 1'b0;

  // Transaction timeline written by the driver, read by the compare process.
  int          t_start = -1;
  logic        t_fast  = 1'b0;
  int          t_end   = 1 << 30;
  logic [31:0] t_res   = 32'd0;
  logic [31:0] exp_result = 32'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  logic in_calc, e_done, e_stall;
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst_edge) exp_result = 32'd0;
      in_calc = (t_start >= 0) && !t_fast && (cyc >= t_start + 1) &&
                (cyc <= t_start + 32) && (cyc < t_end);
      e_done  = (t_start >= 0) && (cyc == t_start + (t_fast ? 1 : 33)) && (cyc < t_end);
      e_stall = in_calc || (cyc == t_start);
      if (e_done) begin
        exp_result = t_res;
        $display("txn cyc=%0d done result=%h", cyc, result);
      end
      check("stall_req", {31'd0, stall_req}, {31'd0, e_stall});
      check("busy",      {31'd0, busy},      {31'd0, in_calc});
      check("done",      {31'd0, done},      {31'd0, e_done});
      check("result",    result,             exp_result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for one cycle, pin the model against a hand value, then
  // scramble the operand buses (the DUT must have latched them).
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit);
    start   = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    t_fast  = (op[2] && b == 0) ||
              (op[2] && !op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    t_res   = model(op, a, b);
    t_end   = 1 << 30;
    t_start = cyc;
    check("model_pin", t_res, lit);
    tick();
    start = 1'b0;
    rs1_i = $urandom;
    rs2_i = $urandom;
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit);
    launch(op, a, b, lit);
    repeat (t_fast ? 1 : 33) tick();
  endtask

  logic [2:0]  v_op  [16];
  logic [31:0] v_a   [16];
  logic [31:0] v_b   [16];
  logic [31:0] v_exp [16];

  initial begin
    v_op[0]  = 3'd0; v_a[0]  = 32'd7;        v_b[0]  = 32'hFFFFFFFD; v_exp[0]  = 32'hFFFFFFEB;
    v_op[1]  = 3'd1; v_a[1]  = 32'h80000000; v_b[1]  = 32'h80000000; v_exp[1]  = 32'h40000000;
    v_op[2]  = 3'd3; v_a[2]  = 32'hFFFFFFFF; v_b[2]  = 32'hFFFFFFFF; v_exp[2]  = 32'hFFFFFFFE;
    v_op[3]  = 3'd2; v_a[3]  = 32'hFFFFFFFF; v_b[3]  = 32'd2;        v_exp[3]  = 32'hFFFFFFFF;
    v_op[4]  = 3'd4; v_a[4]  = 32'hFFFFFFF9; v_b[4]  = 32'd2;        v_exp[4]  = 32'hFFFFFFFD;
    v_op[5]  = 3'd6; v_a[5]  = 32'hFFFFFFF9; v_b[5]  = 32'd2;        v_exp[5]  = 32'hFFFFFFFF;
    v_op[6]  = 3'd5; v_a[6]  = 32'd100;      v_b[6]  = 32'd7;        v_exp[6]  = 32'd14;
    v_op[7]  = 3'd7; v_a[7]  = 32'd100;      v_b[7]  = 32'd7;        v_exp[7]  = 32'd2;
    v_op[8]  = 3'd5; v_a[8]  = 32'd5;        v_b[8]  = 32'd0;        v_exp[8]  = 32'hFFFFFFFF;
    v_op[9]  = 3'd7; v_a[9]  = 32'd5;        v_b[9]  = 32'd0;        v_exp[9]  = 32'd5;
    v_op[10] = 3'd4; v_a[10] = 32'h80000000; v_b[10] = 32'hFFFFFFFF; v_exp[10] = 32'h80000000;
    v_op[11] = 3'd6; v_a[11] = 32'h80000000; v_b[11] = 32'hFFFFFFFF; v_exp[11] = 32'd0;
    v_op[12] = 3'd4; v_a[12] = 32'd100;      v_b[12] = 32'hFFFFFFF9; v_exp[12] = 32'hFFFFFFF2;
    v_op[13] = 3'd6; v_a[13] = 32'd100;      v_b[13] = 32'hFFFFFFF9; v_exp[13] = 32'd2;
    v_op[14] = 3'd1; v_a[14] = 32'hFFFFFFFE; v_b[14] = 32'd3;        v_exp[14] = 32'hFFFFFFFF;
    v_op[15] = 3'd5; v_a[15] = 32'hFFFFFFFF; v_b[15] = 32'd1;        v_exp[15] = 32'hFFFFFFFF;

    // Reset held across several edges; checks begin while it is still high.
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      $display("txn %0d op=%0d a=%h b=%h expect=%h", i, v_op[i], v_a[i], v_b[i], v_exp[i]);
      run(v_op[i], v_a[i], v_b[i], v_exp[i]);
      tick();
    end

    // Flush at cycle 10 of a DIV, new MUL launched in cycle 11.
    $display("txn flush DIV then MUL 3*4");
    launch(3'd4, 32'd1000, 32'd3, 32'd333);
    repeat (9) tick();
    flush = 1'b1;
    t_end = cyc + 1;
    tick();
    flush = 1'b0;
    launch(3'd0, 32'd3, 32'd4, 32'd12);
    repeat (33) tick();
    tick();

    // start together with flush in IDLE is ignored.
    $display("txn start with flush in IDLE");
    start = 1'b1;
    flush = 1'b1;
    op_i  = 3'd0;
    rs1_i = 32'd9;
    rs2_i = 32'd9;
    tick();
    start = 1'b0;
    flush = 1'b0;
    repeat (3) tick();

    // A start pulse while busy is ignored; exactly one done follows.
    $display("txn MUL 9*9 with start while busy");
    launch(3'd0, 32'd9, 32'd9, 32'd81);
    repeat (4) tick();
    start = 1'b1;
    op_i  = 3'd5;
    rs1_i = 32'd50;
    rs2_i = 32'd0;
    tick();
    start = 1'b0;
    repeat (28) tick();
    repeat (5) tick();

    // Reset at cycle 5 of a MUL.
    $display("txn rst mid MUL");
    launch(3'd0, 32'd5, 32'd6, 32'd30);
    repeat (4) tick();
    rst   = 1'b1;
    t_end = cyc + 1;
    tick();
    rst = 1'b0;
    repeat (36) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
